// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between WB (priority) and a
// FIFO-buffered mult/div unit; exports a pending-write mask and a drain stall. Rev 1.0
`default_nettype none

module rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask,
  output logic        stall_req
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = PW + 1;
  localparam logic [3:0]    C_MAXW  = 4'(MAX_WAIT);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [4:0]       ent_rd_q   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       wait_q, wait_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic [31:0]      pend_q, pend_d;
  logic             stall_q, stall_d;

  logic             wb_win, full, found, issue, push;
  logic [CW-1:0]    head_off, pop;
  logic [PW-1:0]    head_idx;

  function automatic logic [PW-1:0] wrap(input logic [SW-1:0] s);
    wrap = (s >= SW'(DEPTH)) ? PW'(s - SW'(DEPTH)) : PW'(s);
  endfunction

  always_comb begin
    wb_win   = wb_we && (wb_rd != 5'd0);
    full     = (count_q == C_DEPTH);
    found    = 1'b0;
    head_off = '0;
    // First valid occupied entry; leading killed entries are skipped for free
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CW'(i) < count_q) && vld_q[wrap(SW'(rd_ptr_q) + SW'(i))]) begin
        found    = 1'b1;
        head_off = CW'(i);
      end
    end
    head_idx = wrap(SW'(rd_ptr_q) + SW'(head_off));
    issue    = !wb_win && found;
    pop      = issue ? (head_off + CW'(1)) : (found ? head_off : count_q);
    push     = md_valid && !full && (md_rd != 5'd0);

    vld_d = vld_q;
    for (int j = 0; j < DEPTH; j++) begin
      if (wb_win && (ent_rd_q[j] == wb_rd)) vld_d[j] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < pop) vld_d[wrap(SW'(rd_ptr_q) + SW'(i))] = 1'b0;
    end
    if (push) vld_d[wr_ptr_q] = !(wb_win && (wb_rd == md_rd));

    rd_ptr_d = wrap(SW'(rd_ptr_q) + SW'(pop));
    wr_ptr_d = push ? wrap(SW'(wr_ptr_q) + SW'(1)) : wr_ptr_q;
    count_d  = count_q - pop + CW'(push);

    pend_d = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (vld_d[j])
        pend_d = pend_d | (32'd1 << ((push && (wr_ptr_q == PW'(j))) ? md_rd : ent_rd_q[j]));
    end

    if (issue || (vld_d == '0))            wait_d = 4'd0;
    else if (found && wb_win && (wait_q != C_MAXW)) wait_d = wait_q + 4'd1;
    else                                   wait_d = wait_q;
    stall_d = (wait_d == C_MAXW);

    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_win) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = wb_rd;
      rf_wdata_d = wb_data;
    end else if (issue) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = ent_rd_q[head_idx];
      rf_wdata_d = ent_data_q[head_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
      pend_q     <= 32'd0;
      stall_q    <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      pend_q     <= pend_d;
      stall_q    <= stall_d;
    end
  end

  // Payload storage needs no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= md_rd;
      ent_data_q[wr_ptr_q] <= md_data;
    end
  end

  assign md_ready  = !full;
  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;
  assign pend_mask = pend_q;
  assign stall_req = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vector table, async-reset sequence and randomized
// traffic against a queue-based model of the arbiter. Rev 1.0
`default_nettype none

module tb_rf_write_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready, rf_we, stall_req;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata, pend_mask;

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
    .md_ready(md_ready), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of results, each with a still-wanted flag
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        mq[$];
  int          m_wait;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic [31:0] m_pend;
  logic        m_stall;

  task automatic model_reset();
    mq.delete();
    m_wait = 0; m_we = 0; m_rd = 0; m_wd = 0; m_pend = 0; m_stall = 0;
  endtask

  task automatic model_step(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                            input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bit   was_full, head_valid, wbwin, issued, any;
    ent_t e;
    was_full = (mq.size() == DEPTH);
    while (mq.size() > 0 && !mq[0].v) void'(mq.pop_front());
    head_valid = (mq.size() > 0);
    wbwin  = we && (wrd != 0);
    issued = 0;
    if (wbwin) begin
      m_we = 1; m_rd = wrd; m_wd = wd;
      foreach (mq[i]) if (mq[i].rd == wrd) mq[i].v = 0;
    end else if (head_valid) begin
      e = mq.pop_front();
      m_we = 1; m_rd = e.rd; m_wd = e.d;
      issued = 1;
    end else begin
      m_we = 0;
    end
    if (mv && !was_full && mrd != 0) begin
      e.rd = mrd; e.d = md; e.v = !(wbwin && wrd == mrd);
      mq.push_back(e);
    end
    any = 0;
    m_pend = 0;
    foreach (mq[i]) if (mq[i].v) begin any = 1; m_pend[mq[i].rd] = 1'b1; end
    if (issued || !any) m_wait = 0;
    else if (head_valid && wbwin && m_wait < MAX_WAIT) m_wait++;
    m_stall = (m_wait == MAX_WAIT);
  endtask

  task automatic cmp_model();
    chk("model rf_we", 32'(rf_we), 32'(m_we));
    chk("model rf_rd", 32'(rf_rd), 32'(m_rd));
    chk("model rf_wdata", rf_wdata, m_wd);
    chk("model pend_mask", pend_mask, m_pend);
    chk("model stall_req", 32'(stall_req), 32'(m_stall));
    chk("model md_ready", 32'(md_ready), 32'(mq.size() != DEPTH));
  endtask

  task automatic apply(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    wb_we = we; wb_rd = wrd; wb_data = wd;
    md_valid = mv; md_rd = mrd; md_data = md;
    @(posedge clk);
    model_step(we, wrd, wd, mv, mrd, md);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic        wbwe;  logic [4:0] wbrd; logic [31:0] wbd;
    logic        mv;    logic [4:0] mrd;  logic [31:0] md;
    logic        ewe;   logic [4:0] erd;  logic [31:0] ewd;
    logic [31:0] epend; logic estall;     logic erdy;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic [4:0] b, input logic [31:0] c,
                              input logic d, input logic [4:0] e, input logic [31:0] f,
                              input logic g, input logic [4:0] h, input logic [31:0] k,
                              input logic [31:0] l, input logic m, input logic n);
    vec_t v;
    v.wbwe = a; v.wbrd = b; v.wbd = c; v.mv = d; v.mrd = e; v.md = f;
    v.ewe = g; v.erd = h; v.ewd = k; v.epend = l; v.estall = m; v.erdy = n;
    return v;
  endfunction

  vec_t vt[24];

  initial begin
    // inputs (wb_we, wb_rd, wb_data, md_valid, md_rd, md_data) -> outputs after the edge
    vt[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            32'h0,   0, 1);
    vt[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 5, 32'hDEADBEEF, 32'h0,   0, 1);
    vt[2]  = mk(0, 0, 0,            0, 0, 0,            0, 5, 32'hDEADBEEF, 32'h0,   0, 1);
    vt[3]  = mk(0, 0, 0,            1, 8, 32'h12345678, 0, 5, 32'hDEADBEEF, 32'h100, 0, 1);
    vt[4]  = mk(0, 0, 0,            0, 0, 0,            1, 8, 32'h12345678, 32'h0,   0, 1);
    vt[5]  = mk(1, 0, 32'hAAAA,     0, 0, 0,            0, 8, 32'h12345678, 32'h0,   0, 1);
    vt[6]  = mk(0, 0, 0,            1, 0, 32'h5555,     0, 8, 32'h12345678, 32'h0,   0, 1);
    // WB hogs the port: FIFO fills, then stall after MAX_WAIT losing cycles
    vt[7]  = mk(1, 1, 32'h11,       1, 10, 32'hA0,      1, 1, 32'h11,       32'h400, 0, 1);
    vt[8]  = mk(1, 1, 32'h12,       1, 11, 32'hB0,      1, 1, 32'h12,       32'hC00, 0, 0);
    vt[9]  = mk(1, 1, 32'h13,       1, 12, 32'hC0,      1, 1, 32'h13,       32'hC00, 0, 0);
    vt[10] = mk(1, 1, 32'h14,       0, 0, 0,            1, 1, 32'h14,       32'hC00, 0, 0);
    vt[11] = mk(1, 1, 32'h15,       0, 0, 0,            1, 1, 32'h15,       32'hC00, 1, 0);
    vt[12] = mk(1, 1, 32'h16,       0, 0, 0,            1, 1, 32'h16,       32'hC00, 1, 0);
    vt[13] = mk(0, 0, 0,            0, 0, 0,            1, 10, 32'hA0,      32'h800, 0, 1);
    vt[14] = mk(0, 0, 0,            0, 0, 0,            1, 11, 32'hB0,      32'h0,   0, 1);
    // Kill of a queued entry, then kill of the entry pushed in the same cycle
    vt[15] = mk(1, 3, 32'h33,       1, 9, 32'h99,       1, 3, 32'h33,       32'h200, 0, 1);
    vt[16] = mk(1, 9, 32'h77,       0, 0, 0,            1, 9, 32'h77,       32'h0,   0, 1);
    vt[17] = mk(0, 0, 0,            0, 0, 0,            0, 9, 32'h77,       32'h0,   0, 1);
    vt[18] = mk(0, 0, 0,            0, 0, 0,            0, 9, 32'h77,       32'h0,   0, 1);
    vt[19] = mk(1, 4, 32'h44,       1, 4, 32'h4444,     1, 4, 32'h44,       32'h0,   0, 1);
    vt[20] = mk(0, 0, 0,            0, 0, 0,            0, 4, 32'h44,       32'h0,   0, 1);
    // Push and pop in the same cycle
    vt[21] = mk(0, 0, 0,            1, 6, 32'h66,       0, 4, 32'h44,       32'h40,  0, 1);
    vt[22] = mk(0, 0, 0,            1, 7, 32'h77,       1, 6, 32'h66,       32'h80,  0, 1);
    vt[23] = mk(0, 0, 0,            0, 0, 0,            1, 7, 32'h77,       32'h0,   0, 1);

    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset pend_mask", pend_mask, 32'd0);
    chk("reset stall_req", 32'(stall_req), 32'd0);
    chk("reset md_ready", 32'(md_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    foreach (vt[i]) begin
      apply(vt[i].wbwe, vt[i].wbrd, vt[i].wbd, vt[i].mv, vt[i].mrd, vt[i].md);
      chk($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(vt[i].ewe));
      chk($sformatf("vec%0d rf_rd", i), 32'(rf_rd), 32'(vt[i].erd));
      chk($sformatf("vec%0d rf_wdata", i), rf_wdata, vt[i].ewd);
      chk($sformatf("vec%0d pend_mask", i), pend_mask, vt[i].epend);
      chk($sformatf("vec%0d stall_req", i), 32'(stall_req), 32'(vt[i].estall));
      chk($sformatf("vec%0d md_ready", i), 32'(md_ready), 32'(vt[i].erdy));
    end

    // Asynchronous reset with two results queued: outputs clear without a clock edge
    apply(1, 1, 32'h1, 1, 20, 32'h2020);
    apply(1, 1, 32'h2, 1, 21, 32'h2121);
    chk("queued pend_mask", pend_mask, 32'h0030_0000);
    #2 rst = 1'b0;
    #1;
    chk("async rf_we", 32'(rf_we), 32'd0);
    chk("async rf_rd", 32'(rf_rd), 32'd0);
    chk("async rf_wdata", rf_wdata, 32'd0);
    chk("async pend_mask", pend_mask, 32'd0);
    chk("async stall_req", 32'(stall_req), 32'd0);
    chk("async md_ready", 32'(md_ready), 32'd1);
    wb_we = 1'b0; md_valid = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
    chk("post-reset no drain", 32'(rf_we), 32'd0);

    // Random traffic: small register range provokes kills; heavy WB phase provokes stalls
    for (int c = 0; c < 800; c++) begin
      logic we, mv;
      we = (c < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      mv = ($urandom_range(0, 1) != 0);
      apply(we, 5'($urandom_range(0, 7)), $urandom(), mv, 5'($urandom_range(0, 7)), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
